xnor_psum_accum_binarize: RTL

Downstream consumer of the XNOR convolution PE array. It takes the signed 5-bit per-channel partial sums (range -9..+9) and their valid strobe, and accumulates them across NUM_CH input channels per output pixel. It thresholds each pixel total into a 1-bit activation, with batch-norm folded into the threshold and a sign-invert flag. Activations are packed LSB-first into PACK_W-bit words and handed to the next layer's buffer over a valid/ready handshake.

---
 rtl/xnor_psum_accum_binarize.sv | 133 +++++++++++++
 1 files changed

// File: rtl/xnor_psum_accum_binarize.sv
// Accumulates signed XNOR partial sums over NUM_CH channels, thresholds each pixel to one bit, packs PACK_W bits per word.
// Latency: act_valid rises 1 cycle after the final beat; backpressure stalls psum_ready (registered) while a word waits in HOLD.
// Optional ACC_SAT_EN: saturating accumulator instead of two's-complement wrap.
module xnor_psum_accum_binarize #(
  parameter int NUM_CH = 16,
  parameter int ACC_W  = 10,
  parameter int PACK_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        psum_in,
  input  logic              psum_valid,
  output logic              psum_ready,
  input  logic              thr_wr_en,
  input  logic [ACC_W-1:0]  thr_in,
  input  logic              thr_inv_in,
  input  logic              flush,
  output logic [PACK_W-1:0] act_out,
  output logic              act_valid,
  input  logic              act_ready
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PIX_W = (PACK_W > 1) ? $clog2(PACK_W) : 1;

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CH_W-1:0]          ch_cnt_q, ch_cnt_d;
  logic [PIX_W-1:0]         pix_cnt_q, pix_cnt_d;
  logic [PACK_W-1:0]        pack_q, pack_d;
  logic signed [ACC_W-1:0]  thr_q;
  logic                     thr_inv_q;

  logic                     beat;
  logic                     last_ch;
  logic                     last_pix;
  logic signed [ACC_W-1:0]  acc_next;
  logic                     act_bit;

  assign beat     = psum_valid && (state_q == ACCUM);
  assign last_ch  = (ch_cnt_q == CH_W'(NUM_CH - 1));
  assign last_pix = (pix_cnt_q == PIX_W'(PACK_W - 1));

`ifdef ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W:0] sum_wide;

  // One guard bit: the top two bits disagree exactly when the true sum left the ACC_W range.
  always_comb begin
    sum_wide = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-4){psum_in[4]}}, psum_in};
    acc_next = sum_wide[ACC_W-1:0];
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      acc_next = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end
`else
  always_comb begin
    acc_next = acc_q + {{(ACC_W-5){psum_in[4]}}, psum_in};
  end
`endif

  // Uses the registered threshold, so a same-cycle write only affects later pixels.
  assign act_bit = thr_inv_q ? (acc_next < thr_q) : (acc_next >= thr_q);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    ch_cnt_d  = ch_cnt_q;
    pix_cnt_d = pix_cnt_q;
    pack_d    = pack_q;
    case (state_q)
      ACCUM: begin
        if (beat) begin
          if (last_ch) begin
            acc_d             = '0;
            ch_cnt_d          = '0;
            pack_d[pix_cnt_q] = act_bit;
            if (last_pix) begin
              pix_cnt_d = '0;
              state_d   = HOLD;
            end else begin
              pix_cnt_d = pix_cnt_q + PIX_W'(1);
            end
          end else begin
            acc_d    = acc_next;
            ch_cnt_d = ch_cnt_q + CH_W'(1);
          end
        end else if (flush && (ch_cnt_q == '0) && (pix_cnt_q != '0)) begin
          pix_cnt_d = '0;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (act_ready) begin
          state_d = ACCUM;
          pack_d  = '0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      ch_cnt_q  <= '0;
      pix_cnt_q <= '0;
      pack_q    <= '0;
      thr_q     <= '0;
      thr_inv_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      ch_cnt_q  <= ch_cnt_d;
      pix_cnt_q <= pix_cnt_d;
      pack_q    <= pack_d;
      if (thr_wr_en) begin
        thr_q     <= thr_in;
        thr_inv_q <= thr_inv_in;
      end
    end
  end

  assign psum_ready = (state_q == ACCUM);
  assign act_valid  = (state_q == HOLD);
  assign act_out    = (state_q == HOLD) ? pack_q : '0;

endmodule
